// File: rtl/btn_step_gen_if.sv
// Button/step bundle between the raw-button front end and the up/down counter.
// The slave side is the conditioning block; the master side drives raw buttons.
interface btn_step_gen_if;
  logic btn_up_raw;
  logic btn_dn_raw;
  logic up;
  logic step;
  logic busy;

  modport master (
    output btn_up_raw,
    output btn_dn_raw,
    input  up,
    input  step,
    input  busy
  );

  modport slave (
    input  btn_up_raw,
    input  btn_dn_raw,
    output up,
    output step,
    output busy
  );
endinterface

// File: rtl/btn_step_gen.sv
// Push-button conditioner: 2-FF sync, debounce, press pulse, auto-repeat and
// two-button lockout, producing a direction and a one-cycle step strobe.
module btn_step_gen #(
  parameter int unsigned DB_CYCLES    = 4,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 8,
  parameter int unsigned CW           = 8
) (
  input  logic            clk,
  input  logic            reset,
  btn_step_gen_if.slave   bus
);

  localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD_UP = 2'd1,
    HOLD_DN = 2'd2,
    LOCK    = 2'd3
  } state_t;

  logic [1:0]    up_sync_q;
  logic [1:0]    dn_sync_q;
  logic          deb_up_q;
  logic          deb_up_d;
  logic          deb_dn_q;
  logic          deb_dn_d;
  logic [CW-1:0] up_db_cnt_q;
  logic [CW-1:0] up_db_cnt_d;
  logic [CW-1:0] dn_db_cnt_q;
  logic [CW-1:0] dn_db_cnt_d;

  state_t        state_q;
  logic [CW-1:0] rpt_cnt_q;
  logic          rpt_first_q;
  logic          step_q;
  logic          up_q;
  logic          busy_q;

  // Returns {next debounced level, next counter}; level only moves after
  // DB_CYCLES consecutive mismatching samples.
  function automatic logic [CW:0] db_next(input logic          sync_lvl,
                                          input logic          deb_lvl,
                                          input logic [CW-1:0] cnt);
    logic [CW:0] nxt;
    if (sync_lvl == deb_lvl) begin
      nxt = {deb_lvl, {CW{1'b0}}};
    end else if (cnt == DB_LAST) begin
      nxt = {sync_lvl, {CW{1'b0}}};
    end else begin
      nxt = {deb_lvl, cnt + CNT_ONE};
    end
    return nxt;
  endfunction

  // Two-stage synchronizers for both raw buttons.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_sync_q <= 2'b00;
      dn_sync_q <= 2'b00;
    end else begin
      up_sync_q <= {up_sync_q[0], bus.btn_up_raw};
      dn_sync_q <= {dn_sync_q[0], bus.btn_dn_raw};
    end
  end

  // Debounce next-state for both buttons.
  always_comb begin
    {deb_up_d, up_db_cnt_d} = db_next(up_sync_q[1], deb_up_q, up_db_cnt_q);
    {deb_dn_d, dn_db_cnt_d} = db_next(dn_sync_q[1], deb_dn_q, dn_db_cnt_q);
  end

  // Debounced levels and their stability counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_up_q    <= 1'b0;
      deb_dn_q    <= 1'b0;
      up_db_cnt_q <= {CW{1'b0}};
      dn_db_cnt_q <= {CW{1'b0}};
    end else begin
      deb_up_q    <= deb_up_d;
      deb_dn_q    <= deb_dn_d;
      up_db_cnt_q <= up_db_cnt_d;
      dn_db_cnt_q <= dn_db_cnt_d;
    end
  end

  // Step FSM with registered outputs; the repeat counter measures the delay
  // to the first repeat, then the shorter period between later repeats.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rpt_cnt_q   <= {CW{1'b0}};
      rpt_first_q <= 1'b0;
      step_q      <= 1'b0;
      up_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      step_q <= 1'b0;
      busy_q <= deb_up_q | deb_dn_q;
      case (state_q)
        IDLE: begin
          if (deb_up_q && deb_dn_q) begin
            state_q <= LOCK;
          end else if (deb_up_q) begin
            step_q      <= 1'b1;
            up_q        <= 1'b1;
            rpt_cnt_q   <= {CW{1'b0}};
            rpt_first_q <= 1'b1;
            state_q     <= HOLD_UP;
          end else if (deb_dn_q) begin
            step_q      <= 1'b1;
            up_q        <= 1'b0;
            rpt_cnt_q   <= {CW{1'b0}};
            rpt_first_q <= 1'b1;
            state_q     <= HOLD_DN;
          end else begin
            state_q <= IDLE;
          end
        end
        HOLD_UP, HOLD_DN: begin
          if ((state_q == HOLD_UP) ? !deb_up_q : !deb_dn_q) begin
            state_q <= IDLE;
          end else if ((state_q == HOLD_UP) ? deb_dn_q : deb_up_q) begin
            state_q <= LOCK;
          end else if (rpt_cnt_q == (rpt_first_q ? DELAY_LAST : RATE_LAST)) begin
            step_q      <= 1'b1;
            rpt_cnt_q   <= {CW{1'b0}};
            rpt_first_q <= 1'b0;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + CNT_ONE;
          end
        end
        LOCK: begin
          if (!deb_up_q && !deb_dn_q) begin
            state_q <= IDLE;
          end else begin
            state_q <= LOCK;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.step = step_q;
  assign bus.up   = up_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_btn_step_gen.sv
// Scoreboard bench for btn_step_gen: stimulus queues expected step edges,
// a negedge monitor pops and compares every observed step pulse.
module tb_btn_step_gen;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  btn_step_gen_if bus ();

  btn_step_gen #(
    .DB_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_RATE(8), .CW(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the number of the last rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   edge_n;
    logic up;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_step(input int edge_n, input logic up);
    exp_t e;
    e.edge_n = edge_n;
    e.up     = up;
    exp_q.push_back(e);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_step"}, {31'd0, bus.step}, 32'd0);
    check({tag, "_up"},   {31'd0, bus.up},   32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // Monitor: every step pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.step === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_step: got step at edge %0d expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("step_edge", cyc, e.edge_n);
        check("step_up", {31'd0, bus.up}, {31'd0, e.up});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int e1;
    logic [13:0] bounce;
    bounce = 14'b11111111110011;

    // Reset with toggling buttons
    reset = 1'b1;
    bus.btn_up_raw = 1'b1;
    bus.btn_dn_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("reset");
      bus.btn_up_raw = ~bus.btn_up_raw;
      bus.btn_dn_raw = ~bus.btn_dn_raw;
    end
    reset = 1'b0;
    bus.btn_up_raw = 1'b0;
    bus.btn_dn_raw = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");
    wait_edge(cyc + 10);

    // Clean up press held 12 edges
    e0 = cyc + 1;
    bus.btn_up_raw = 1'b1;
    expect_step(e0 + 6, 1'b1);
    wait_edge(e0 + 5);
    check("busy_before_deb", {31'd0, bus.busy}, 32'd0);
    wait_edge(e0 + 6);
    check("busy_after_deb", {31'd0, bus.busy}, 32'd1);
    wait_edge(e0 + 11);
    bus.btn_up_raw = 1'b0;
    wait_edge(e0 + 17);
    check("busy_hold_release", {31'd0, bus.busy}, 32'd1);
    wait_edge(e0 + 18);
    check("busy_fall_release", {31'd0, bus.busy}, 32'd0);
    wait_edge(cyc + 10);

    // Bouncy up press: clean run starts at E4
    e0 = cyc + 1;
    expect_step(e0 + 10, 1'b1);
    for (int k = 0; k < 14; k++) begin
      bus.btn_up_raw = bounce[k];
      @(negedge clk);
    end
    bus.btn_up_raw = 1'b0;
    wait_edge(cyc + 15);

    // Auto-repeat on down held 45 edges
    e0 = cyc + 1;
    bus.btn_dn_raw = 1'b1;
    expect_step(e0 + 6,  1'b0);
    expect_step(e0 + 22, 1'b0);
    expect_step(e0 + 30, 1'b0);
    expect_step(e0 + 38, 1'b0);
    expect_step(e0 + 46, 1'b0);
    wait_edge(e0 + 44);
    bus.btn_dn_raw = 1'b0;
    wait_edge(e0 + 70);
    check("busy_after_dn", {31'd0, bus.busy}, 32'd0);

    // Simultaneous press: lockout, then up alone works
    e0 = cyc + 1;
    bus.btn_up_raw = 1'b1;
    bus.btn_dn_raw = 1'b1;
    wait_edge(e0 + 10);
    check("busy_lock", {31'd0, bus.busy}, 32'd1);
    wait_edge(e0 + 19);
    bus.btn_up_raw = 1'b0;
    bus.btn_dn_raw = 1'b0;
    wait_edge(e0 + 30);
    e1 = cyc + 1;
    bus.btn_up_raw = 1'b1;
    expect_step(e1 + 6, 1'b1);
    wait_edge(e1 + 7);
    bus.btn_up_raw = 1'b0;
    wait_edge(cyc + 12);

    // Up repeating, then down pressed: lock before the E30 repeat
    e0 = cyc + 1;
    bus.btn_up_raw = 1'b1;
    expect_step(e0 + 6,  1'b1);
    expect_step(e0 + 22, 1'b1);
    wait_edge(e0 + 22);
    bus.btn_dn_raw = 1'b1;
    wait_edge(e0 + 50);
    check("busy_lock_hold", {31'd0, bus.busy}, 32'd1);
    check("up_held_in_lock", {31'd0, bus.up}, 32'd1);
    bus.btn_up_raw = 1'b0;
    bus.btn_dn_raw = 1'b0;
    wait_edge(cyc + 15);
    check("busy_lock_release", {31'd0, bus.busy}, 32'd0);

    // Reset during up repeat phase, button kept held
    e0 = cyc + 1;
    bus.btn_up_raw = 1'b1;
    expect_step(e0 + 6,  1'b1);
    expect_step(e0 + 22, 1'b1);
    wait_edge(e0 + 24);
    reset = 1'b1;
    wait_edge(e0 + 25);
    check_idle_outputs("mid_reset1");
    wait_edge(e0 + 26);
    check_idle_outputs("mid_reset2");
    reset = 1'b0;
    expect_step(e0 + 33, 1'b1);
    wait_edge(e0 + 36);
    bus.btn_up_raw = 1'b0;
    wait_edge(cyc + 25);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btn_step_gen.md
Name: btn_step_gen

Overview:
- Input conditioning stage that sits directly upstream of the up/down counter. It feeds that counter's `up` direction input and supplies a single-cycle count-enable strobe.
- Converts two raw push-buttons (up, down) into clean stepping commands:
  - 2-FF synchronization;
  - per-button debounce;
  - press-edge pulse generation;
  - auto-repeat while a button is held;
  - lockout when both buttons are pressed.

Parameters:
DB_CYCLES, 4, consecutive stable cycles required before a debounced level changes (>=2)
REPEAT_DELAY, 16, cycles from press pulse to first auto-repeat pulse (>=2)
REPEAT_RATE, 8, cycles between subsequent auto-repeat pulses (>=2)
CW, 8, width of debounce and repeat counters; must hold max(DB_CYCLES, REPEAT_DELAY)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
btn_up_raw  input  1  raw asynchronous up button, active-high
btn_dn_raw  input  1  raw asynchronous down button, active-high
up  output  1  registered direction to counter: 1 = count up, 0 = count down
step  output  1  registered one-cycle strobe: counter advances one position in direction `up`
busy  output  1  high while any debounced button is pressed

Behaviour:
- Clocking: one clock (`clk`); reset is synchronous and active-high (`reset`). All state updates on the rising edge of `clk`.
- Reset: while `reset` is high at an edge, all of the following clear to 0:
  - sync FFs;
  - debounced levels;
  - debounce counters;
  - repeat counter;
  - FSM returns to IDLE.
  - Outputs during reset: `up`=0, `step`=0, `busy`=0.
  - Reset wins over every other event.
- Synchronizer: s1 <= raw, s2 <= s1, separately per button.
- Debounce, per button:
  - If s2 == deb, the counter clears.
  - Otherwise the counter increments; at the edge where counter == DB_CYCLES-1 and the mismatch persists, deb <= s2 and the counter clears.
  - Any return of s2 to deb before that clears the counter.
- Latency: raw level first sampled at edge E0 → deb flips at E0+DB_CYCLES+1 → `step` is high for the cycle following edge E0+DB_CYCLES+2.
- FSM states:
  - IDLE:
    - deb_up rises alone → `step`=1, `up`=1, repeat counter cleared, go to HOLD_UP.
    - deb_dn rises alone → `step`=1, `up`=0, go to HOLD_DN.
    - Both rise in the same cycle → go to LOCK, no pulse.
  - HOLD_UP / HOLD_DN:
    - The repeat counter increments each cycle.
    - First repeat `step` comes REPEAT_DELAY cycles after the press pulse; thereafter one every REPEAT_RATE cycles.
    - Held button's deb falls → IDLE, no pulse.
    - Other button's deb rises → LOCK, repeating stops immediately, no pulse.
  - LOCK: no pulses. Go to IDLE only when both deb levels are 0.
- Output rules:
  - `step` is never high for two consecutive cycles, since REPEAT_RATE >= 2.
  - `up` changes only in the same cycle as a press-pulse `step`; it otherwise holds its value.
  - busy = deb_up | deb_dn, registered.
- Reset mid-hold: after reset releases with a button still physically held, the full sync+debounce latency applies again from the first post-reset edge, and exactly one fresh press pulse is produced.
- Counter width: repeat and debounce counters are CW bits; counter wrap is unreachable under the parameter constraints.

Test Plan:
(All scenarios use default parameters.)
- Reset: reset high 3 cycles with both raw buttons toggling → `step`=0, `up`=0, `busy`=0 throughout and on the first cycle after release.
- Clean up press: btn_up_raw=1 from E0 for 12 cycles, then 0 → exactly one `step` in the cycle after E6 with `up`=1; no further pulses; `busy` falls DB_CYCLES+2 edges after release.
- Bounce: raw up pattern 1,1,0,0,1,1,1,1,1... starting E0 → single `step` in the cycle after E10 (clean run starts at E4); no pulse from the short runs.
- Auto-repeat: hold btn_dn_raw 45 cycles, first pulse at cycle P → `step` at P, P+16, P+24, P+32, P+40, `up`=0; no pulse on release.
- Simultaneous: both raw high at the same edge for 20 cycles → no `step`, `busy`=1. Release both, then press up alone → one `step` with `up`=1. Also: up held in repeat, then down pressed → repeating stops, no pulse until both released.
- Reset mid-hold: reset asserted 2 cycles during HOLD_UP repeat phase, button kept high → `step`/`up` go to 0. After release, exactly one `step` arrives DB_CYCLES+2 edges after the first post-reset edge.
